// File: rtl/spi_write_ctrl_if.sv
// Bus bundle for spi_write_ctrl: start/data handshake from the controlling
// FSM plus the registered SPI pins and busy/done status.
//   start_i  transfer request (level, sampled in IDLE)
//   data_i   word to send, captured on accept
//   busy_o   transfer in progress (accept edge until return to IDLE)
//   done_o   one-cycle pulse as cs_no rises
//   sclk_o   SPI clock, mode 0
//   mosi_o   SPI data out, MSB first
//   cs_no    SPI chip select, active low
// master: controller side, slave: spi_write_ctrl side.
interface spi_write_ctrl_if #(
    parameter int DataWidth = 16
);
    logic                 start_i;
    logic [DataWidth-1:0] data_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 sclk_o;
    logic                 mosi_o;
    logic                 cs_no;

    modport master (
        output start_i, data_i,
        input  busy_o, done_o, sclk_o, mosi_o, cs_no
    );

    modport slave (
        input  start_i, data_i,
        output busy_o, done_o, sclk_o, mosi_o, cs_no
    );
endinterface

// File: rtl/spi_write_ctrl.sv
// SPI mode-0 write-only master. Sends one DataWidth word MSB first per
// accepted start, sclk half-period = ClkDiv system clocks, framed by cs_no.
// Ports:
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset, aborts any transfer
//   bus     spi_write_ctrl_if.slave (start_i, data_i, busy_o, done_o,
//           sclk_o, mosi_o, cs_no); all outputs registered
//
// state | meaning
// IDLE  | waiting for start_i, cs_no high, sclk low
// LOW   | sclk low half-period, current bit on mosi
// HIGH  | sclk high half-period, slave samples on the rising edge
// HOLD  | sclk low after last bit, cs_no still low
// GAP   | cs_no high recovery time, still busy
module spi_write_ctrl #(
    parameter int DataWidth = 16,
    parameter int ClkDiv    = 4,
    parameter int DivWidth  = 8,
    parameter int BitWidth  = 5
) (
    input logic              clk_i,
    input logic              rst_ni,
    spi_write_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;

    localparam logic [DivWidth-1:0] DivLast = DivWidth'(ClkDiv - 1);
    localparam logic [BitWidth-1:0] BitLast = BitWidth'(DataWidth - 1);

    state_t               state_q, state_d;
    logic [DivWidth-1:0]  div_q, div_d;
    logic [BitWidth-1:0]  bit_q, bit_d;
    logic [DataWidth-1:0] shift_q, shift_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 cs_q, cs_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 phase_end;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;

        phase_end = (div_q == DivLast);
        // Counter sits at zero in IDLE so every phase starts from a full count.
        div_d = (state_q == IDLE || phase_end) ? '0 : div_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    shift_d = bus.data_i;
                    bit_d   = '0;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (phase_end) state_d = HIGH;
            end
            HIGH: begin
                if (phase_end) begin
                    if (bit_q < BitLast) begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {shift_q[DataWidth-2:0], 1'b0};
                        state_d = LOW;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_d = GAP;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                if (phase_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so each pin
        // changes exactly on the edge that enters the corresponding phase.
        sclk_d = (state_d == HIGH);
        cs_d   = (state_d == IDLE) || (state_d == GAP);
        busy_d = (state_d != IDLE);
        mosi_d = (state_d == LOW || state_d == HIGH || state_d == HOLD) ?
                 shift_d[DataWidth-1] : 1'b0;
    end

    assign bus.sclk_o = sclk_q;
    assign bus.mosi_o = mosi_q;
    assign bus.cs_no  = cs_q;
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;

endmodule

// File: tb/tb_spi_write_ctrl.sv
module tb_spi_write_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    logic sel;

    spi_write_ctrl_if #(.DataWidth(16)) ia ();
    spi_write_ctrl_if #(.DataWidth(16)) ib ();

    spi_write_ctrl #(.DataWidth(16), .ClkDiv(4), .DivWidth(8), .BitWidth(5)) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ia)
    );

    spi_write_ctrl #(.DataWidth(16), .ClkDiv(1), .DivWidth(8), .BitWidth(5)) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ib)
    );

    typedef struct {
        logic        sel;
        logic [15:0] data;
        int          poke_off;
        logic [15:0] poke_data;
        logic [15:0] exp_word;
        int          exp_low;
        int          exp_done;
        int          exp_busy;
    } vec_t;

    vec_t tbl[7];

    int n_cmp;
    int n_bad;
    int cur;

    int cs_fall_q[$];
    int cs_rise_q[$];
    int done_q[$];
    int busy_fall_q[$];
    int word_q[$];
    int rise_q[$];
    int viol;

    logic m_sclk, m_mosi, m_cs, m_busy, m_done;

    always_comb begin
        m_sclk = sel ? ib.sclk_o : ia.sclk_o;
        m_mosi = sel ? ib.mosi_o : ia.mosi_o;
        m_cs   = sel ? ib.cs_no  : ia.cs_no;
        m_busy = sel ? ib.busy_o : ia.busy_o;
        m_done = sel ? ib.done_o : ia.done_o;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Slave-side observer: shifts mosi in on every sclk rise and records
    // frame boundaries and protocol violations with cycle stamps.
    initial begin
        logic        p_sclk, p_mosi, p_cs, p_busy;
        logic [15:0] fw;
        int          fr;
        p_sclk = 1'b0; p_mosi = 1'b0; p_cs = 1'b1; p_busy = 1'b0;
        fw = '0; fr = 0;
        forever begin
            @(negedge clk);
            if (p_cs && !m_cs) begin
                cs_fall_q.push_back(cyc);
                fw = '0;
                fr = 0;
            end
            if (!p_sclk && m_sclk) begin
                fw = {fw[14:0], m_mosi};
                fr++;
            end
            if (m_sclk && m_cs) viol++;
            if (m_cs && m_mosi) viol++;
            if (!m_cs && !p_cs && (m_mosi != p_mosi) && !(p_sclk && !m_sclk)) viol++;
            if (!p_cs && m_cs) begin
                cs_rise_q.push_back(cyc);
                word_q.push_back(int'(fw));
                rise_q.push_back(fr);
            end
            if (m_done) done_q.push_back(cyc);
            if (p_busy && !m_busy) busy_fall_q.push_back(cyc);
            p_sclk = m_sclk; p_mosi = m_mosi; p_cs = m_cs; p_busy = m_busy;
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation time limit reached, got no finish expected finish");
        $fatal(1, "timeout");
    end

    function automatic void check(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (vec %0d): got %0d (0x%0h) expected %0d (0x%0h)",
                     name, cur, got, got, exp, exp);
        end
    endfunction

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1000000;
    endfunction

    function automatic void clear_mon();
        cs_fall_q.delete();
        cs_rise_q.delete();
        done_q.delete();
        busy_fall_q.delete();
        word_q.delete();
        rise_q.delete();
        viol = 0;
    endfunction

    task automatic drive(input logic s, input logic st, input logic [15:0] d);
        if (s) begin
            ib.start_i = st;
            ib.data_i  = d;
        end else begin
            ia.start_i = st;
            ia.data_i  = d;
        end
    endtask

    // Reference timing from the frame rules: cs low for (2*bits+1) half
    // periods, busy for one more half period.
    function automatic vec_t make_vec(input logic s, input logic [15:0] d,
                                      input int poke, input logic [15:0] pd);
        vec_t v;
        int   div;
        div         = s ? 1 : 4;
        v.sel       = s;
        v.data      = d;
        v.poke_off  = poke;
        v.poke_data = pd;
        v.exp_word  = d;
        v.exp_low   = div * (2 * 16 + 1);
        v.exp_done  = div * (2 * 16 + 1);
        v.exp_busy  = div * (2 * 16 + 2);
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int e0;
        @(negedge clk);
        sel = v.sel;
        clear_mon();
        drive(v.sel, 1'b1, v.data);
        e0 = cyc + 1;
        for (int t = 0; t <= v.exp_busy + 6; t++) begin
            @(negedge clk);
            if (t == 0) drive(v.sel, 1'b0, ~v.data);
            if (v.poke_off > 0 && t == v.poke_off) drive(v.sel, 1'b1, v.poke_data);
            if (v.poke_off > 0 && t == v.poke_off + 1) drive(v.sel, 1'b0, v.poke_data);
        end
        check("frames",    cs_fall_q.size(), 1);
        check("cs_fall",   qat(cs_fall_q, 0) - e0, 0);
        check("cs_low",    qat(cs_rise_q, 0) - qat(cs_fall_q, 0), v.exp_low);
        check("word",      qat(word_q, 0), v.exp_word);
        check("rises",     qat(rise_q, 0), 16);
        check("done_cnt",  done_q.size(), 1);
        check("done_at",   qat(done_q, 0) - e0, v.exp_done);
        check("busy_fall", qat(busy_fall_q, 0) - e0, v.exp_busy);
        check("violations", viol, 0);
    endtask

    initial begin
        int e0;

        tbl[0] = '{1'b0, 16'hA5C3, 0,  16'h0000, 16'hA5C3, 132, 132, 136};
        tbl[1] = '{1'b0, 16'h1234, 50, 16'hFFFF, 16'h1234, 132, 132, 136};
        tbl[2] = '{1'b1, 16'h8001, 0,  16'h0000, 16'h8001, 33,  33,  34};
        tbl[3] = '{1'b1, 16'h00FF, 10, 16'hAAAA, 16'h00FF, 33,  33,  34};
        tbl[4] = '{1'b0, 16'h0000, 0,  16'h0000, 16'h0000, 132, 132, 136};
        tbl[5] = '{1'b0, 16'hFFFF, 135, 16'h5555, 16'hFFFF, 132, 132, 136};
        tbl[6] = '{1'b0, 16'h00FF, 0,  16'h0000, 16'h00FF, 132, 132, 136};

        n_cmp = 0; n_bad = 0; cur = -1; viol = 0;
        sel = 1'b0;
        rst_n = 1'b0;
        ia.start_i = 1'b0; ia.data_i = '0;
        ib.start_i = 1'b0; ib.data_i = '0;

        // Reset while idle.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sclk", ia.sclk_o, 0);
        check("rst_mosi", ia.mosi_o, 0);
        check("rst_cs",   ia.cs_no,  1);
        check("rst_busy", ia.busy_o, 0);
        check("rst_done", ia.done_o, 0);
        check("rst_cs_b", ib.cs_no,  1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table vectors.
        for (int i = 0; i < 7; i++) begin
            cur = i;
            run_vec(tbl[i]);
        end

        // Back-to-back with start held high.
        cur = 100;
        @(negedge clk);
        sel = 1'b0;
        clear_mon();
        drive(1'b0, 1'b1, 16'h0001);
        e0 = cyc + 1;
        @(negedge clk);
        drive(1'b0, 1'b1, 16'h8000);
        repeat (150) @(negedge clk);
        drive(1'b0, 1'b0, 16'h8000);
        repeat (140) @(negedge clk);
        check("b2b_frames", cs_fall_q.size(), 2);
        check("b2b_word0",  qat(word_q, 0), 16'h0001);
        check("b2b_word1",  qat(word_q, 1), 16'h8000);
        check("b2b_e1",     qat(cs_fall_q, 1) - e0, 137);
        check("b2b_cs_gap", qat(cs_fall_q, 1) - qat(cs_rise_q, 0), 5);
        check("b2b_done_n", done_q.size(), 2);
        check("b2b_done_d", qat(done_q, 1) - qat(done_q, 0), 137);
        check("b2b_viol",   viol, 0);

        // Asynchronous reset mid-transfer.
        cur = 101;
        @(negedge clk);
        sel = 1'b0;
        clear_mon();
        drive(1'b0, 1'b1, 16'hC3C3);
        e0 = cyc + 1;
        @(negedge clk);
        drive(1'b0, 1'b0, 16'hC3C3);
        repeat (40) @(negedge clk);
        check("mid_cs_before", ia.cs_no, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_cs",   ia.cs_no,  1);
        check("mid_sclk", ia.sclk_o, 0);
        check("mid_busy", ia.busy_o, 0);
        check("mid_mosi", ia.mosi_o, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_no_done", done_q.size(), 0);
        cur = 6;
        run_vec(tbl[6]);

        // Randomized transfers against the frame-level reference.
        for (int i = 0; i < 30; i++) begin
            logic        s;
            logic [15:0] d;
            int          poke;
            cur  = 200 + i;
            s    = 1'($urandom_range(0, 1));
            d    = 16'($urandom);
            poke = 0;
            if ($urandom_range(0, 1) == 1)
                poke = int'($urandom_range(1, (s ? 1 : 4) * 34 - 1));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_vec(make_vec(s, d, poke, 16'($urandom)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
